// File: rtl/mux_src_arbiter_pkg.sv
// Shared definitions for the mux source arbiter.
//   state_t  : FSM state encoding (2-bit)
//   DW_DEF   : default channel / mux data width
//   CNT_W    : width of the settle counter (HOLD range 0..15)
package mux_src_arbiter_pkg;

    localparam int DW_DEF = 8;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

endpackage

// File: rtl/mux_src_arbiter_rr_pick4.sv
// Combinational 4-way round-robin picker.
//   pending [3:0] in  : channels holding a byte
//   last    [1:0] in  : channel most recently retired
//   grant   [1:0] out : first pending channel searching from last+1, wrapping 3->0
//   any           out : at least one channel is pending
module rr_pick4 (
    input  logic [3:0] pending,
    input  logic [1:0] last,
    output logic [1:0] grant,
    output logic       any
);

    logic       found;
    logic [1:0] idx;

    always_comb begin
        grant = 2'd0;
        found = 1'b0;
        idx   = 2'd0;
        any   = |pending;
        // k=4 wraps back to 'last' itself, which is therefore checked last.
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && pending[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_src_arbiter.sv
// Upstream source stage for the 4:1 byte mux. Captures bytes from four
// producer channels, picks one pending channel round-robin, drives the mux
// data inputs and select, waits HOLD settle cycles, then presents sel_valid
// until the consumer acknowledges.
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid/in_ready : per-channel producer handshake (4 bits each)
//   in_data0..3       : per-channel producer bytes
//   i0..i3            : registered channel bytes to the mux data inputs
//   s1, s0            : registered select, {s1,s0} = granted channel
//   sel_valid, sel_ack: consumer handshake for the selected byte
//   busy              : FSM not in IDLE
//
// Handshake: a producer byte transfers on a rising edge where
// in_valid[k] & in_ready[k]; in_ready[k] is low while channel k holds an
// unretired byte. The selection retires on an edge where sel_valid & sel_ack.
module mux_src_arbiter
    import mux_src_arbiter_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int HOLD = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    in_valid,
    output logic [3:0]    in_ready,
    input  logic [DW-1:0] in_data0,
    input  logic [DW-1:0] in_data1,
    input  logic [DW-1:0] in_data2,
    input  logic [DW-1:0] in_data3,
    output logic [DW-1:0] i0,
    output logic [DW-1:0] i1,
    output logic [DW-1:0] i2,
    output logic [DW-1:0] i3,
    output logic          s1,
    output logic          s0,
    output logic          sel_valid,
    input  logic          sel_ack,
    output logic          busy
);

    // HOLD-1 as the counter preload; unused when HOLD is zero.
    localparam logic [CNT_W-1:0] HOLD_M1 = (HOLD == 0) ? '0 : CNT_W'(HOLD - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       sel;
    logic [1:0]       last;
    logic [3:0]       pending;
    logic [3:0]       pending_nxt;
    logic [3:0]       load;
    logic             retire;
    logic [1:0]       grant;
    logic             any;
    logic [DW-1:0]    data_q  [4];
    logic [DW-1:0]    data_in [4];

    assign data_in[0] = in_data0;
    assign data_in[1] = in_data1;
    assign data_in[2] = in_data2;
    assign data_in[3] = in_data3;

    assign in_ready = ~pending;
    assign load     = in_valid & in_ready;
    assign retire   = (state == ST_PRESENT) && sel_ack;
    assign busy     = (state != ST_IDLE);

    assign i0 = data_q[0];
    assign i1 = data_q[1];
    assign i2 = data_q[2];
    assign i3 = data_q[3];
    assign s1 = sel[1];
    assign s0 = sel[0];

    // A channel never loads and retires on the same edge (ready is low while
    // pending), so set and clear never collide on one bit.
    always_comb begin
        pending_nxt = pending | load;
        if (retire) begin
            pending_nxt = pending_nxt & ~(4'b0001 << sel);
        end
    end

    rr_pick4 u_pick (
        .pending (pending),
        .last    (last),
        .grant   (grant),
        .any     (any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            sel       <= 2'd0;
            last      <= 2'd3;
            pending   <= 4'd0;
            sel_valid <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            pending <= pending_nxt;
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    data_q[k] <= data_in[k];
                end
            end
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        sel <= grant;
                        cnt <= HOLD_M1;
                        if (HOLD == 0) begin
                            state     <= ST_PRESENT;
                            sel_valid <= 1'b1;
                        end else begin
                            state <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (cnt == '0) begin
                        state     <= ST_PRESENT;
                        sel_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_PRESENT: begin
                    if (sel_ack) begin
                        sel_valid <= 1'b0;
                        last      <= sel;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_src_arbiter.sv
module tb_mux_src_arbiter;

    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A: HOLD=2 ----------------
    logic [3:0]    in_valid = '0;
    logic [3:0]    in_ready;
    logic [DW-1:0] in_data0 = '0, in_data1 = '0, in_data2 = '0, in_data3 = '0;
    logic [DW-1:0] i0, i1, i2, i3;
    logic          s1, s0, sel_valid, busy;
    logic          sel_ack = 1'b0;

    mux_src_arbiter #(.DW(DW), .HOLD(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
        .i0(i0), .i1(i1), .i2(i2), .i3(i3),
        .s1(s1), .s0(s0), .sel_valid(sel_valid), .sel_ack(sel_ack), .busy(busy)
    );

    // ---------------- DUT B: HOLD=0 ----------------
    logic [3:0]    b_in_valid = '0;
    logic [3:0]    b_in_ready;
    logic [DW-1:0] b_in_data0 = '0, b_in_data1 = '0, b_in_data2 = '0, b_in_data3 = '0;
    logic [DW-1:0] b_i0, b_i1, b_i2, b_i3;
    logic          b_s1, b_s0, b_sel_valid, b_busy;
    logic          b_sel_ack = 1'b0;

    mux_src_arbiter #(.DW(DW), .HOLD(0)) dut_h0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data0(b_in_data0), .in_data1(b_in_data1), .in_data2(b_in_data2), .in_data3(b_in_data3),
        .i0(b_i0), .i1(b_i1), .i2(b_i2), .i3(b_i3),
        .s1(b_s1), .s0(b_s0), .sel_valid(b_sel_valid), .sel_ack(b_sel_ack), .busy(b_busy)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [1:0]    exp_q   [$];
    logic [DW-1:0] exp_d_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] sel_byte();
        case ({s1, s0})
            2'd0:    return i0;
            2'd1:    return i1;
            2'd2:    return i2;
            default: return i3;
        endcase
    endfunction

    task automatic wait_sel_valid(input string tag);
        int n = 0;
        while (!sel_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq(tag, {31'd0, sel_valid}, 32'd1);
    endtask

    task automatic do_ack(input string tag);
        sel_ack = 1'b1;
        tick();
        sel_ack = 1'b0;
        check_eq(tag, {31'd0, sel_valid}, 32'd0);
    endtask

    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        #10;
        rst_n = 1'b1;
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0]    e;
        logic [DW-1:0] ed;

        // 1: reset state
        #12;
        check_eq("rst_i0", i0, 0);
        check_eq("rst_i1", i1, 0);
        check_eq("rst_i2", i2, 0);
        check_eq("rst_i3", i3, 0);
        check_eq("rst_sel", {s1, s0}, 0);
        check_eq("rst_sel_valid", sel_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_in_ready", in_ready, 4'hF);
        check_eq("rst_b_in_ready", b_in_ready, 4'hF);
        check_eq("rst_b_busy", b_busy, 0);
        rst_n = 1'b1;
        tick();

        // 2: single transfer on ch2, HOLD=2
        in_valid[2] = 1'b1;
        in_data2 = 8'hA5;
        tick();                       // E0
        in_valid[2] = 1'b0;
        check_eq("t2_ready_low", in_ready[2], 0);
        tick();                       // E1
        check_eq("t2_grant", {s1, s0}, 2'b10);
        check_eq("t2_i2", i2, 8'hA5);
        check_eq("t2_busy", busy, 1);
        check_eq("t2_sv_e1", sel_valid, 0);
        tick();                       // E2
        check_eq("t2_sv_e2", sel_valid, 0);
        tick();                       // E3
        check_eq("t2_sv_e3", sel_valid, 1);
        do_ack("t2_ack_sv");          // E4
        check_eq("t2_ready_back", in_ready[2], 1);
        check_eq("t2_busy_idle", busy, 0);

        // 3: fairness from reset (last=3): 0,1,2,3, then reloaded ch0
        apply_reset();
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_d_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20};
        in_valid = 4'hF;
        in_data0 = 8'h10; in_data1 = 8'h11; in_data2 = 8'h12; in_data3 = 8'h13;
        tick();
        in_valid = 4'h0;
        for (int n = 0; n < 5; n++) begin
            wait_sel_valid("t3_wait");
            e = exp_q.pop_front();
            ed = exp_d_q.pop_front();
            check_eq("t3_rr_grant", {s1, s0}, e);
            check_eq("t3_rr_data", sel_byte(), ed);
            do_ack("t3_ack_sv");
            if (n == 0) begin
                in_valid[0] = 1'b1;
                in_data0 = 8'h20;
                tick();
                in_valid[0] = 1'b0;
            end
        end
        // last=0 now: retire ch1 to make last=1, then ch0+ch3 -> ch3 wins
        in_valid[1] = 1'b1; in_data1 = 8'h31;
        tick();
        in_valid[1] = 1'b0;
        wait_sel_valid("t3b_wait1");
        check_eq("t3b_grant1", {s1, s0}, 2'd1);
        do_ack("t3b_ack1");
        in_valid = 4'b1001; in_data0 = 8'h40; in_data3 = 8'h43;
        tick();
        in_valid = 4'h0;
        wait_sel_valid("t3b_wait3");
        check_eq("t3b_grant3", {s1, s0}, 2'd3);
        check_eq("t3b_data3", sel_byte(), 8'h43);
        do_ack("t3b_ack3");
        wait_sel_valid("t3b_wait0");
        check_eq("t3b_grant0", {s1, s0}, 2'd0);
        do_ack("t3b_ack0");

        // 4: backpressure in PRESENT on ch1
        in_valid[1] = 1'b1; in_data1 = 8'h3C;
        tick();
        in_data1 = 8'hFF;             // reload attempt while pending
        wait_sel_valid("t4_wait");
        for (int n = 0; n < 20; n++) begin
            if (n == 5) begin
                in_valid[3] = 1'b1; in_data3 = 8'h77;
            end
            tick();
            if (n == 5) in_valid[3] = 1'b0;
            check_eq("t4_sv", sel_valid, 1);
            check_eq("t4_sel", {s1, s0}, 2'd1);
            check_eq("t4_i1", i1, 8'h3C);
            check_eq("t4_ready1", in_ready[1], 0);
        end
        check_eq("t4_ch3_loaded", in_ready[3], 0);
        in_valid[1] = 1'b0;
        do_ack("t4_ack");
        wait_sel_valid("t4_wait3");
        check_eq("t4_grant3", {s1, s0}, 2'd3);
        check_eq("t4_i3", i3, 8'h77);
        do_ack("t4_ack3");

        // 5: async reset in SETTLE
        in_valid = 4'b0101; in_data0 = 8'h50; in_data2 = 8'h52;
        tick();
        in_valid = 4'h0;
        tick();                       // grant taken, now SETTLE
        check_eq("t5_busy_pre", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_busy", busy, 0);
        check_eq("t5_sel", {s1, s0}, 0);
        check_eq("t5_i0", i0, 0);
        check_eq("t5_i2", i2, 0);
        check_eq("t5_ready", in_ready, 4'hF);
        #3;
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            tick();
            check_eq("t5_no_grant_sv", sel_valid, 0);
            check_eq("t5_no_grant_busy", busy, 0);
        end

        // 6: HOLD=0 instance
        b_in_valid[1] = 1'b1; b_in_data1 = 8'h5A;
        tick();                       // E0
        b_in_valid[1] = 1'b0;
        check_eq("t6_sv_e0", b_sel_valid, 0);
        tick();                       // E1
        check_eq("t6_grant", {b_s1, b_s0}, 2'd1);
        check_eq("t6_sv_e1", b_sel_valid, 1);
        check_eq("t6_i1", b_i1, 8'h5A);
        b_sel_ack = 1'b1;
        tick();
        check_eq("t6_ack_sv", b_sel_valid, 0);
        check_eq("t6_ready", b_in_ready, 4'hF);
        for (int n = 0; n < 3; n++) begin
            tick();                   // stray ack held in IDLE
            check_eq("t6_stray_busy", b_busy, 0);
            check_eq("t6_stray_sv", b_sel_valid, 0);
            check_eq("t6_stray_sel", {b_s1, b_s0}, 2'd1);
        end
        b_sel_ack = 1'b0;

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
